// File: rtl/muldiv_pkg.sv
// Shared definitions for the Mult/Div sequencer slice.
//   muldiv_state_t      : sequencer FSM states
//   SEL_DIV / SEL_MULT  : DivMultHigh/Low mux select encodings
//   MAX_CYCLES_DEFAULT  : default watchdog limit (launch to unit done)
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    M_RUN,
    D_RUN,
    WB
  } muldiv_state_t;

  localparam logic SEL_DIV  = 1'b0;
  localparam logic SEL_MULT = 1'b1;

  localparam int MAX_CYCLES_DEFAULT = 40;

endpackage

// File: rtl/muldiv_watchdog.sv
// Watchdog up-counter for the sequencer.
// Ports:
//   clock   in  system clock, rising edge
//   reset   in  asynchronous active-high reset
//   clear   in  synchronous clear to zero (wins over enable)
//   enable  in  count one step this cycle
//   expired out count has reached MAX_CYCLES-1
module muldiv_watchdog
  import muldiv_pkg::*;
#(
  parameter int MAX_CYCLES = MAX_CYCLES_DEFAULT,
  parameter int CNT_W      = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the multicycle Mult and Div units for the main control FSM:
// launches the selected unit, waits for its completion, drives the
// DivMultHigh/Low select and High/Low writes, and reports divide-by-zero,
// watchdog timeout and protocol misuse. All outputs are registered.
// Ports:
//   clock, reset             clock and asynchronous active-high reset
//   start_mult, start_div    1-cycle requests from control
//   op_b                     divisor, sampled with start_div
//   abort                    flush; cancels any operation in flight
//   mult_done, div_done      unit result valid
//   mult_start, div_start    1-cycle unit launch pulses
//   unit_clear               1-cycle clear to both units (abort/timeout)
//   muldiv_sel               result mux select: 0=Div, 1=Mult
//   hi_write, lo_write, done writeback strobes (1 cycle)
//   busy                     operation in flight
//   div_zero_exc, timeout, seq_err  1-cycle error pulses
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MAX_CYCLES = MAX_CYCLES_DEFAULT,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] op_b,
  input  logic        abort,
  input  logic        mult_done,
  input  logic        div_done,
  output logic        mult_start,
  output logic        div_start,
  output logic        unit_clear,
  output logic        muldiv_sel,
  output logic        hi_write,
  output logic        lo_write,
  output logic        busy,
  output logic        done,
  output logic        div_zero_exc,
  output logic        timeout,
  output logic        seq_err
);

  muldiv_state_t state;
  logic          expired;
  logic          any_start;
  logic          unit_done;

  assign any_start = start_mult | start_div;
  // Only the unit actually launched can complete the operation.
  assign unit_done = (state == M_RUN) ? mult_done : div_done;

  // Counter sits at zero while idle and counts from the launch cycle, so
  // expiry lands MAX_CYCLES-1 cycles after the start pulse.
  muldiv_watchdog #(
    .MAX_CYCLES(MAX_CYCLES),
    .CNT_W     (CNT_W)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (state == IDLE),
    .enable ((state == LAUNCH) || (state == M_RUN) || (state == D_RUN)),
    .expired(expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      mult_start   <= 1'b0;
      div_start    <= 1'b0;
      unit_clear   <= 1'b0;
      muldiv_sel   <= SEL_DIV;
      hi_write     <= 1'b0;
      lo_write     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      div_zero_exc <= 1'b0;
      timeout      <= 1'b0;
      seq_err      <= 1'b0;
    end else begin
      mult_start   <= 1'b0;
      div_start    <= 1'b0;
      unit_clear   <= 1'b0;
      hi_write     <= 1'b0;
      lo_write     <= 1'b0;
      done         <= 1'b0;
      div_zero_exc <= 1'b0;
      timeout      <= 1'b0;
      seq_err      <= 1'b0;

      if (abort) begin
        // Abort overrides everything, including a completion or request
        // sampled this cycle, so no writeback can follow it.
        state      <= IDLE;
        busy       <= 1'b0;
        unit_clear <= (state != IDLE);
      end else begin
        case (state)
          IDLE: begin
            if (start_mult && start_div) begin
              seq_err <= 1'b1;
            end else if (start_mult) begin
              state      <= LAUNCH;
              mult_start <= 1'b1;
              muldiv_sel <= SEL_MULT;
              busy       <= 1'b1;
            end else if (start_div) begin
              if (op_b == 32'd0) begin
                div_zero_exc <= 1'b1;
              end else begin
                state      <= LAUNCH;
                div_start  <= 1'b1;
                muldiv_sel <= SEL_DIV;
                busy       <= 1'b1;
              end
            end
          end
          LAUNCH: begin
            // The latched select remembers which unit was launched.
            if (muldiv_sel == SEL_MULT) begin
              state <= M_RUN;
            end else begin
              state <= D_RUN;
            end
            seq_err <= any_start;
          end
          M_RUN, D_RUN: begin
            if (unit_done) begin
              state    <= WB;
              hi_write <= 1'b1;
              lo_write <= 1'b1;
              done     <= 1'b1;
              seq_err  <= any_start;
            end else if (expired) begin
              // Timeout outranks a stray request in the same cycle.
              state      <= IDLE;
              busy       <= 1'b0;
              timeout    <= 1'b1;
              unit_clear <= 1'b1;
            end else begin
              seq_err <= any_start;
            end
          end
          WB: begin
            state   <= IDLE;
            busy    <= 1'b0;
            seq_err <= any_start;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
